// File: rtl/dot_stream_mac.sv
// Streaming multi-lane dot-product engine: two-stage multiply/accumulate over valid/ready beats.
// Optional DOT_SAT_EN: saturating accumulation with sticky out_ovf; otherwise modulo wrap.
module dot_stream_mac #(
  parameter int LANES = 4,
  parameter int W     = 16,
  parameter int ACC_W = 48,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*W-1:0]   in_a,
  input  logic [LANES*W-1:0]   in_b,
  input  logic [LANES-1:0]     in_mask,
  input  logic                 in_last,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_sum,
  output logic [CNT_W-1:0]     out_beats,
  output logic                 out_ovf
);

  localparam int P_W   = 2 * W;
  localparam int TOT_W = ACC_W + $clog2(LANES) + 2;

  localparam logic [1:0] ST_ACC  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic                       first_q, first_d;
  logic                       mode_q, mode_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       s1_valid_q, s1_valid_d;
  logic                       s1_first_q, s1_first_d;
  logic                       s1_signed_q, s1_signed_d;
  logic [LANES-1:0][P_W-1:0]  prod_q, prod_d;
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic signed [TOT_W-1:0]    lane_sum, base, total;
  logic                       beat_acc;
  logic                       beat_sgn;
`ifdef DOT_SAT_EN
  localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic                       ovf_q, ovf_d;
  logic                       clamp;
  logic [ACC_W-1:0]           sat_val;
`endif

  // Low 2W bits of the product of the extended operands equal the signed or unsigned product.
  function automatic logic [P_W-1:0] mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sgn);
    logic [P_W-1:0] ea, eb;
    ea = sgn ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = sgn ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  function automatic logic signed [TOT_W-1:0] ext_p(input logic [P_W-1:0] p, input logic sgn);
    return sgn ? {{(TOT_W-P_W){p[P_W-1]}}, p} : {{(TOT_W-P_W){1'b0}}, p};
  endfunction

  function automatic logic signed [TOT_W-1:0] ext_acc(input logic [ACC_W-1:0] v, input logic sgn);
    return sgn ? {{(TOT_W-ACC_W){v[ACC_W-1]}}, v} : {{(TOT_W-ACC_W){1'b0}}, v};
  endfunction

  assign in_ready  = (state_q == ST_ACC);
  assign out_valid = (state_q == ST_HOLD);
  assign out_sum   = acc_q;
  assign out_beats = cnt_q;
  assign beat_acc  = in_valid & in_ready;
  assign beat_sgn  = first_q ? in_signed : mode_q;

  // Control: vector framing, mode latch, beat counter and result handshake.
  always_comb begin
    state_d = state_q;
    first_d = first_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    if (beat_acc) begin
      first_d = in_last;
      if (first_q) mode_d = in_signed;
      if (first_q)       cnt_d = CNT_W'(1);
      else if (!(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
    end
    case (state_q)
      ST_ACC:  if (beat_acc && in_last) state_d = ST_WAIT;
      ST_WAIT: state_d = ST_HOLD;
      ST_HOLD: if (out_ready) state_d = ST_ACC;
      default: state_d = ST_ACC;
    endcase
  end

  always_comb begin
    s1_valid_d  = beat_acc;
    s1_first_d  = first_q;
    s1_signed_d = beat_sgn;
    for (int i = 0; i < LANES; i++)
      prod_d[i] = in_mask[i] ? mul(in_a[i*W +: W], in_b[i*W +: W], beat_sgn) : '0;
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) lane_sum = lane_sum + ext_p(prod_q[i], s1_signed_q);
    base  = s1_first_q ? '0 : ext_acc(acc_q, s1_signed_q);
    total = base + lane_sum;
    acc_d = acc_q;
`ifdef DOT_SAT_EN
    ovf_d   = ovf_q;
    clamp   = 1'b0;
    sat_val = ACC_W'(total);
    if (s1_signed_q) begin
      // In range only when every bit above the result sign agrees with it.
      if ((|total[TOT_W-1:ACC_W-1]) && !(&total[TOT_W-1:ACC_W-1])) begin
        clamp   = 1'b1;
        sat_val = total[TOT_W-1] ? S_MIN : S_MAX;
      end
    end else if (|total[TOT_W-1:ACC_W]) begin
      clamp   = 1'b1;
      sat_val = '1;
    end
    if (s1_valid_q) begin
      acc_d = sat_val;
      ovf_d = (s1_first_q ? 1'b0 : ovf_q) | clamp;
    end
`else
    if (s1_valid_q) acc_d = ACC_W'(total);
`endif
  end

`ifdef DOT_SAT_EN
  assign out_ovf = ovf_q;
`else
  assign out_ovf = 1'b0;
`endif

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ACC;
      first_q     <= 1'b1;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_signed_q <= 1'b0;
      // NOTE: the lane-product array is plain flops, so it is reset along with everything else.
      prod_q      <= '0;
      acc_q       <= '0;
`ifdef DOT_SAT_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_signed_q <= s1_signed_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
`ifdef DOT_SAT_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_dot_stream_mac.sv
// Self-checking bench for dot_stream_mac: 48-bit and 32-bit accumulator instances share one stream,
// compared every cycle against a per-beat arithmetic model; expectations follow DOT_SAT_EN.
module tb_dot_stream_mac;
  localparam int LANES = 4;
  localparam int W     = 16;
  localparam int CNT_W = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic [LANES*W-1:0]   in_a = '0;
  logic [LANES*W-1:0]   in_b = '0;
  logic [LANES-1:0]     in_mask = '0;
  logic                 in_last = 1'b0;
  logic                 in_signed = 1'b0;
  logic                 out_ready = 1'b0;

  logic                 in_ready, out_valid, out_ovf;
  logic [47:0]          out_sum;
  logic [CNT_W-1:0]     out_beats;
  logic                 in_ready32, out_valid32, out_ovf32;
  logic [31:0]          out_sum32;
  logic [CNT_W-1:0]     out_beats32;

  dot_stream_mac #(.LANES(LANES), .W(W), .ACC_W(48), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_mask(in_mask), .in_last(in_last), .in_signed(in_signed), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_beats(out_beats), .out_ovf(out_ovf));

  dot_stream_mac #(.LANES(LANES), .W(W), .ACC_W(32), .CNT_W(CNT_W)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .in_a(in_a), .in_b(in_b),
    .in_mask(in_mask), .in_last(in_last), .in_signed(in_signed), .out_valid(out_valid32),
    .out_ready(out_ready), .out_sum(out_sum32), .out_beats(out_beats32), .out_ovf(out_ovf32));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One accumulation step of width w: exact sum, then clamp or wrap.
  task automatic acc_step(input longint acc, input longint c, input int w, input bit sgn,
                          output longint r, output bit clamp);
    longint t, mx, mn;
    t = acc + c;
    clamp = 1'b0;
`ifdef DOT_SAT_EN
    if (sgn) begin
      mx = (longint'(1) <<< (w-1)) - 1;
      mn = -(longint'(1) <<< (w-1));
    end else begin
      mx = (longint'(1) << w) - 1;
      mn = 0;
    end
    if (t > mx) begin t = mx; clamp = 1'b1; end
    if (t < mn) begin t = mn; clamp = 1'b1; end
    r = t;
`else
    mx = 0; mn = 0;
    r = t & ((longint'(1) << w) - 1);
`endif
  endtask

  // Model state (written only by the compare process).
  bit     m_wait, m_hold, m_first, m_sgn, m_ovf48, m_ovf32;
  longint m_acc48, m_acc32;
  int     m_beats;
  longint e_sum48, e_sum32;
  int     e_beats;
  bit     e_ovf48, e_ovf32;
  bit     exp_ready, sgn, cl;
  longint c, r;
  logic [W-1:0] la, lb;

  // Results captured at each output handshake, for the hand-computed checks.
  logic [47:0]      cap48;
  logic [31:0]      cap32;
  logic [CNT_W-1:0] cap_beats;
  logic             cap_ovf48, cap_ovf32;

  always @(negedge clk) begin
    if (rst) begin
      m_wait  = 1'b0;
      m_hold  = 1'b0;
      m_first = 1'b1;
    end else begin
      exp_ready = !(m_wait || m_hold);
      check("in_ready", 64'(in_ready), 64'(exp_ready));
      check("in_ready32", 64'(in_ready32), 64'(exp_ready));
      check("out_valid", 64'(out_valid), 64'(m_hold));
      check("out_valid32", 64'(out_valid32), 64'(m_hold));
      if (m_hold) begin
        check("out_sum48", 64'(out_sum), 64'(e_sum48));
        check("out_sum32", 64'(out_sum32), 64'(e_sum32));
        check("out_beats", 64'(out_beats), 64'(e_beats));
        check("out_beats32", 64'(out_beats32), 64'(e_beats));
        check("out_ovf48", 64'(out_ovf), 64'(e_ovf48));
        check("out_ovf32", 64'(out_ovf32), 64'(e_ovf32));
        if (out_ready) begin
          cap48 = out_sum; cap32 = out_sum32; cap_beats = out_beats;
          cap_ovf48 = out_ovf; cap_ovf32 = out_ovf32;
        end
      end
      // Advance the model by one cycle.
      m_hold = (m_hold && !out_ready) || m_wait;
      m_wait = 1'b0;
      if (exp_ready && in_valid) begin
        if (m_first) begin
          m_sgn = in_signed; m_acc48 = 0; m_acc32 = 0;
          m_ovf48 = 1'b0; m_ovf32 = 1'b0; m_beats = 0;
        end
        sgn = m_sgn;
        c = 0;
        for (int i = 0; i < LANES; i++) begin
          if (in_mask[i]) begin
            la = in_a[i*W +: W];
            lb = in_b[i*W +: W];
            if (sgn) c += longint'(shortint'(la)) * longint'(shortint'(lb));
            else     c += longint'(la) * longint'(lb);
          end
        end
        acc_step(m_acc48, c, 48, sgn, r, cl); m_acc48 = r; m_ovf48 |= cl;
        acc_step(m_acc32, c, 32, sgn, r, cl); m_acc32 = r; m_ovf32 |= cl;
        if (m_beats < 65535) m_beats++;
        m_first = in_last;
        if (in_last) begin
          m_wait  = 1'b1;
          e_sum48 = m_acc48 & ((longint'(1) << 48) - 1);
          e_sum32 = m_acc32 & ((longint'(1) << 32) - 1);
          e_beats = m_beats;
          e_ovf48 = m_ovf48;
          e_ovf32 = m_ovf32;
        end
      end
    end
  end

  function automatic logic [63:0] pack4(input logic [15:0] x0, input logic [15:0] x1,
                                        input logic [15:0] x2, input logic [15:0] x3);
    return {x3, x2, x1, x0};
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 4))
      0:       return 16'h8000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic drive_beat(input logic [63:0] a, input logic [63:0] b, input logic [3:0] m,
                            input logic last, input logic sg);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_mask = m; in_last = last; in_signed = sg;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL beat_timeout: in_ready=0 required 1 within 50 cycles");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Waits for out_valid, holds out_ready low for `hold` cycles (optionally offering a beat), then handshakes.
  task automatic wait_result(input int hold, input bit poke);
    int n = 0;
    out_ready = 1'b0;
    @(negedge clk);
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    if (!out_valid) begin
      checks++; failures++;
      $display("FAIL result_timeout: out_valid=0 required 1 within 50 cycles");
      return;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (poke && i == 0) begin
        in_valid = 1'b1; in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
        in_mask = '1; in_last = 1'b1; in_signed = 1'b0;
      end
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [63:0] neg_all, lane0_neg;

  initial begin
    neg_all   = pack4(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    lane0_neg = pack4(16'h8000, 16'h0003, 16'h0004, 16'h0005);

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_out_beats", 64'(out_beats), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single signed beat: 1*5+2*6+3*7+4*8, result two cycles after acceptance.
    drive_beat(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 4'hF, 1'b1, 1'b1);
    @(negedge clk); check("lat_t1_valid", 64'(out_valid), 64'd0);
    @(negedge clk); check("lat_t2_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    wait_result(0, 1'b0);
    check("t1_sum", 64'(cap48), 64'd70);
    check("t1_beats", 64'(cap_beats), 64'd1);
    check("t1_ovf", 64'(cap_ovf48), 64'd0);

    // 16 signed beats of (-32768)^2 on all lanes; mode bit on later beats is ignored.
    for (int i = 0; i < 16; i++) drive_beat(neg_all, neg_all, 4'hF, 1'(i == 15), 1'(i == 0));
    wait_result(0, 1'b0);
    check("t2_sum", 64'(cap48), 64'd68719476736);
    check("t2_beats", 64'(cap_beats), 64'd16);

    // Unsigned then signed single lane with other lanes masked.
    drive_beat(pack4(16'hFFFF, 16'h1234, 16'h0005, 16'h0007),
               pack4(16'hFFFF, 16'h0002, 16'h0003, 16'h0009), 4'b0001, 1'b1, 1'b0);
    wait_result(1, 1'b0);
    check("t3_unsigned", 64'(cap48), 64'hFFFE0001);
    drive_beat(pack4(16'hFFFF, 16'h1234, 16'h0005, 16'h0007),
               pack4(16'hFFFF, 16'h0002, 16'h0003, 16'h0009), 4'b0001, 1'b1, 1'b1);
    wait_result(5, 1'b1);
    check("t3_signed", 64'(cap48), 64'd1);
    @(negedge clk); check("bp_ready_after", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Three beats of 2^30 on lane 0 overflow the 32-bit instance.
    for (int i = 0; i < 3; i++) drive_beat(lane0_neg, lane0_neg, 4'b0001, 1'(i == 2), 1'b1);
    wait_result(2, 1'b0);
    check("t5_sum48", 64'(cap48), 64'hC0000000);
`ifdef DOT_SAT_EN
    check("t5_sum32", 64'(cap32), 64'h7FFFFFFF);
    check("t5_ovf32", 64'(cap_ovf32), 64'd1);
`else
    check("t5_sum32", 64'(cap32), 64'hC0000000);
    check("t5_ovf32", 64'(cap_ovf32), 64'd0);
`endif

    // Reset mid-vector discards the partial vector.
    drive_beat(neg_all, neg_all, 4'hF, 1'b0, 1'b1);
    drive_beat(neg_all, neg_all, 4'hF, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_out_sum", 64'(out_sum), 64'd0);
    check("mid_rst_out_beats", 64'(out_beats), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    drive_beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), 4'hF, 1'b1, 1'b0);
    wait_result(0, 1'b0);
    check("t6_sum", 64'(cap48), 64'd4);
    check("t6_beats", 64'(cap_beats), 64'd1);

    // Randomized vectors: lengths, masks, modes, input gaps and output backpressure.
    for (int v = 0; v < 40; v++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        drive_beat(pack4(rnd16(), rnd16(), rnd16(), rnd16()),
                   pack4(rnd16(), rnd16(), rnd16(), rnd16()),
                   4'($urandom), 1'(k == len - 1), 1'($urandom));
      end
      wait_result($urandom_range(0, 3), 1'($urandom));
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
